avalon_bus_arbiter: RTL and testbench
=====================================

Name: avalon_bus_arbiter

Overview:
- Shares one Avalon-style memory slave (the random-waitrequest RAM model or real memory) between two bus masters: m0 (CPU bus port) and m1 (secondary master, e.g. a loader/DMA or second CPU).
- Round-robin arbitration, grant held for the full transfer including all waitrequest stall cycles.
- Sits between masters and memory in bus-level testbenches and the system top.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- STALL_LIMIT, 1024, consecutive stalled cycles on one transfer before the stall_error flag sets.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_address / m1_address  in  ADDR_W  master addresses.
- m0_read, m0_write / m1_read, m1_write  in  1 each  master requests.
- m0_writedata / m1_writedata  in  DATA_W  master write data.
- m0_byteenable / m1_byteenable  in  DATA_W/8  master byte enables.
- m0_readdata / m1_readdata  out  DATA_W  read data returned to each master.
- m0_waitrequest / m1_waitrequest  out  1  stall to each master.
- s_address  out  ADDR_W; s_read, s_write  out  1; s_writedata  out  DATA_W; s_byteenable  out  DATA_W/8  slave-side request.
- s_readdata  in  DATA_W; s_waitrequest  in  1  slave response.
- grant  out  2  one-hot current owner (01 = m0, 10 = m1, 00 = idle).
- stall_error  out  1  sticky watchdog flag.

Behaviour:
- Request definition: reqN = mN_read | mN_write. A transfer completes in a cycle where the granted master's read or write is high and s_waitrequest = 0.
- FSM states: IDLE, OWN0, OWN1. A last_owner register is reset to 1, so m0 wins the first tie.
- IDLE:
  - s_read = s_write = 0, and both mN_waitrequest = 1.
  - On a clock edge, only req0 -> OWN0; only req1 -> OWN1.
  - On a tie, go to the master that is not last_owner. No requests -> stay in IDLE.
- OWNx (combinational):
  - s_* = mx_*, mx_waitrequest = s_waitrequest, mx_readdata = s_readdata.
  - The other master sees waitrequest = 1.
  - Non-granted readdata = 0, and readdata is 0 in IDLE.
- OWNx transitions:
  - On a completion edge: last_owner <= x. If the other master is requesting, go directly to its OWN state (zero-bubble alternation); otherwise go to IDLE.
  - Back-to-back requests from the same master therefore cost one IDLE cycle. This is required; do not optimise it away.
  - Granted master drops its request without completing (protocol violation) -> IDLE, and last_owner is unchanged.
  - Simultaneous read and write from the granted master are both forwarded unchanged. The arbiter does not filter them.
- Watchdog:
  - A stall counter resets to 0 whenever the state changes or a transfer completes.
  - It increments each cycle in OWNx with s_waitrequest = 1, and saturates at STALL_LIMIT.
  - When it reaches STALL_LIMIT, stall_error <= 1. It is sticky and cleared only by reset.
- Reset values: state IDLE, grant 00, last_owner 1, counter 0, stall_error 0. Therefore s_read = s_write = 0, m0/m1_waitrequest = 1, readdata 0.
- Reset mid-transfer: abandoned. The slave sees read/write drop in the cycle after the reset edge. Neither master is told of completion.
- No combinational path exists from s_waitrequest to grant or state except through the registered FSM. s_waitrequest -> mx_waitrequest is the only combinational slave-to-master path besides readdata.

Decomposition:
- Shared package bus_arb_pkg:
  - State enum (IDLE, OWN0, OWN1).
  - Grant encoding constants GRANT_NONE/GRANT_M0/GRANT_M1.
  - Default widths.
- One natural sub-module: bus_arb_mux, the pure combinational forwarding mux (slave side from the grant; per-master waitrequest and readdata gating). FSM and watchdog stay in the top.

Test Plan:
- After reset, with no requests: grant = 00, s_read = s_write = 0, m0/m1_waitrequest = 1, stall_error = 0.
- m0 reads 0x00000010 with slave waitrequest high for 3 cycles, readdata 0xDEADBEEF:
  - grant = 01 from the next edge.
  - m0_waitrequest mirrors the slave.
  - m0 samples 0xDEADBEEF on the completion cycle.
  - FSM returns to IDLE.
  - m1_waitrequest = 1 throughout.
- m0 and m1 both request from reset: m0 is served first. At m0's completion edge the FSM moves straight to OWN1 with no IDLE cycle. m1's write of 0xCAFEF00D with byteenable 0011 appears on the s_* ports unchanged.
- Both masters hold continuous requests for 8 transfers: grants strictly alternate 01, 10, 01, ... with no IDLE between them.
- m1 repeats a request alone: OWN1, IDLE, OWN1 (one bubble between transfers).
- Slave waitrequest is held high with STALL_LIMIT = 4:
  - stall_error rises exactly on the edge where 4 stalled cycles have elapsed.
  - It stays 1 after the transfer completes.
  - It clears only on reset.
- Reset is asserted during an m1 stall: the next cycle shows s_write = 0 and grant = 00, and m0 (requesting) wins the subsequent arbitration.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared constants and helpers for the two-master Avalon arbiter
package bus_arb_pkg;

  // Default widths and watchdog threshold
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_STALL_LIMIT = 1024;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // One-hot grant encoding seen on the grant port
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // Grant is a pure decode of the registered state, so it never depends on the slave
  function automatic logic [1:0] state_to_grant(input logic [1:0] st);
    logic [1:0] g;
    case (st)
      ST_OWN0: g = GRANT_M0;
      ST_OWN1: g = GRANT_M1;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bus_arb_mux.sv
// rtl/bus_arb_mux.sv - combinational request/response steering between two masters and one slave
module bus_arb_mux
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]          grant,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_waitrequest
);

  // Forward the owner's request to the slave and the slave's response to the owner only;
  // everyone else is stalled and sees zero read data, and the slave sees no command when idle.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_readdata    = '0;
    m1_readdata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (grant)
      GRANT_M0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_readdata    = s_readdata;
        m0_waitrequest = s_waitrequest;
      end
      GRANT_M1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_readdata    = s_readdata;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// rtl/avalon_bus_arbiter.sv - round-robin two-master arbiter for one Avalon slave with stall watchdog
module avalon_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_waitrequest,
  output logic [1:0]          grant,
  output logic                stall_error
);

  localparam int               CNT_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STALL_LIMIT);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             last_owner;   // 0 = m0 completed last, 1 = m1
  logic             complete;
  logic             stalled;
  logic [CNT_W-1:0] stall_cnt;
  logic             req0;
  logic             req1;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign grant = state_to_grant(state);

  // Next-state and completion decode; a completion hands straight over to a waiting peer
  always_comb begin
    state_next = state;
    complete   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0 && req1)  state_next = last_owner ? ST_OWN0 : ST_OWN1;
        else if (req0)     state_next = ST_OWN0;
        else if (req1)     state_next = ST_OWN1;
      end
      ST_OWN0: begin
        if (!req0) begin
          state_next = ST_IDLE;
        end else if (!s_waitrequest) begin
          complete   = 1'b1;
          state_next = req1 ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!req1) begin
          state_next = ST_IDLE;
        end else if (!s_waitrequest) begin
          complete   = 1'b1;
          state_next = req0 ? ST_OWN0 : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A stalled cycle is one where the owner keeps its request and the slave holds it off
  assign stalled = (state != ST_IDLE) && s_waitrequest && (state_next == state);

  // Arbitration state and round-robin history; an abandoned transfer leaves history untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_next;
      if (complete) last_owner <= (state == ST_OWN1);
    end
  end

  // Stall watchdog: counts consecutive stalled cycles of one transfer, flag is sticky until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt   <= '0;
      stall_error <= 1'b0;
    end else if (complete || (state_next != state)) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != LIMIT_C)) begin
      stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt == LIMIT_C - 1'b1) stall_error <= 1'b1;
    end
  end

  bus_arb_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .grant         (grant),
    .m0_address    (m0_address),
    .m0_read       (m0_read),
    .m0_write      (m0_write),
    .m0_writedata  (m0_writedata),
    .m0_byteenable (m0_byteenable),
    .m0_readdata   (m0_readdata),
    .m0_waitrequest(m0_waitrequest),
    .m1_address    (m1_address),
    .m1_read       (m1_read),
    .m1_write      (m1_write),
    .m1_writedata  (m1_writedata),
    .m1_byteenable (m1_byteenable),
    .m1_readdata   (m1_readdata),
    .m1_waitrequest(m1_waitrequest),
    .s_address     (s_address),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_byteenable  (s_byteenable),
    .s_readdata    (s_readdata),
    .s_waitrequest (s_waitrequest)
  );

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb/tb_avalon_bus_arbiter.sv - self-checking bench for avalon_bus_arbiter
module tb_avalon_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic [31:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [1:0]  grant;
  logic        stall_error;

  int n_checks = 0;
  int n_fail   = 0;

  avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant), .stall_error(stall_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
    s_readdata = '0; s_waitrequest = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset grant got=%b exp=00", grant); end
    n_checks++; if (s_read !== 1'b0 || s_write !== 1'b0) begin n_fail++; $display("FAIL reset s_rw got=%b%b exp=00", s_read, s_write); end
    n_checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset waitreq got=%b%b exp=11", m0_waitrequest, m1_waitrequest); end
    n_checks++; if (stall_error !== 1'b0) begin n_fail++; $display("FAIL reset stall_error got=%b exp=0", stall_error); end
    n_checks++; if (m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin n_fail++; $display("FAIL reset readdata got=%h/%h exp=0", m0_readdata, m1_readdata); end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_read = 1; m0_address = 32'h0000_0010; s_waitrequest = 1; s_readdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (grant !== 2'b00 || m0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL single_read pre-grant got grant=%b wr=%b exp 00/1", grant, m0_waitrequest); end
    step();
    n_checks++; if (s_read !== 1'b1 || s_address !== 32'h10) begin n_fail++; $display("FAIL single_read slave req got rd=%b addr=%h exp 1/10", s_read, s_address); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (grant !== 2'b01 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL single_read stall%0d got grant=%b w0=%b w1=%b exp 01/1/1", i, grant, m0_waitrequest, m1_waitrequest); end
      if (i < 2) step();
    end
    s_waitrequest = 0;
    #1;
    n_checks++; if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_read done got wr=%b rd=%h exp 0/deadbeef", m0_waitrequest, m0_readdata); end
    n_checks++; if (m1_waitrequest !== 1'b1 || m1_readdata !== 32'h0) begin n_fail++; $display("FAIL single_read m1 got wr=%b rd=%h exp 1/0", m1_waitrequest, m1_readdata); end
    step();
    m0_read = 0;
    #1;
    n_checks++; if (grant !== 2'b00 || stall_error !== 1'b0) begin n_fail++; $display("FAIL single_read idle got grant=%b err=%b exp 00/0", grant, stall_error); end
  endtask

  task automatic test_tie();
    do_reset();
    m0_read = 1; m0_address = 32'h100;
    m1_write = 1; m1_address = 32'h204; m1_writedata = 32'hCAFE_F00D; m1_byteenable = 4'b0011;
    s_waitrequest = 0;
    step();
    n_checks++; if (grant !== 2'b01 || m0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL tie first got grant=%b w0=%b exp 01/0", grant, m0_waitrequest); end
    step();
    m0_read = 0;
    #1;
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL tie handover got grant=%b exp 10", grant); end
    n_checks++; if (s_write !== 1'b1 || s_read !== 1'b0 || s_writedata !== 32'hCAFE_F00D || s_byteenable !== 4'b0011 || s_address !== 32'h204)
      begin n_fail++; $display("FAIL tie m1 fwd got w=%b r=%b d=%h be=%b a=%h exp 1/0/cafef00d/0011/204", s_write, s_read, s_writedata, s_byteenable, s_address); end
    step();
    m1_write = 0;
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL tie end got grant=%b exp 00", grant); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    do_reset();
    m0_read = 1; m1_read = 1; s_waitrequest = 0;
    step();
    for (int k = 0; k < 8; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL alternate xfer%0d got grant=%b exp %b", k, grant, exp_g); end
      step();
    end
    m0_read = 0; m1_read = 0;
    step();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL alternate end got grant=%b exp 00", grant); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4] = '{2'b10, 2'b00, 2'b10, 2'b00};
    do_reset();
    m1_write = 1; m1_writedata = 32'h1234_5678; s_waitrequest = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) m1_write = 0;
      step();
      n_checks++; if (grant !== seq[k]) begin n_fail++; $display("FAIL back_to_back cyc%0d got grant=%b exp %b", k, grant, seq[k]); end
    end
  endtask

  task automatic test_watchdog();
    logic exp_e;
    do_reset();
    m0_write = 1; s_waitrequest = 1;
    step();
    for (int i = 1; i <= LIMIT + 1; i++) begin
      step();
      exp_e = (i >= LIMIT);
      n_checks++; if (stall_error !== exp_e) begin n_fail++; $display("FAIL watchdog after %0d stalls got=%b exp %b", i, stall_error, exp_e); end
    end
    s_waitrequest = 0;
    step();
    m0_write = 0;
    step();
    n_checks++; if (stall_error !== 1'b1 || grant !== 2'b00) begin n_fail++; $display("FAIL watchdog sticky got err=%b grant=%b exp 1/00", stall_error, grant); end
    do_reset();
    n_checks++; if (stall_error !== 1'b0) begin n_fail++; $display("FAIL watchdog clear got=%b exp 0", stall_error); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_write = 1; m1_address = 32'h40; s_waitrequest = 1;
    step();
    n_checks++; if (grant !== 2'b10 || s_write !== 1'b1) begin n_fail++; $display("FAIL reset_mid own got grant=%b w=%b exp 10/1", grant, s_write); end
    step();
    m0_read = 1; reset = 1;
    step();
    reset = 0;
    #1;
    n_checks++; if (grant !== 2'b00 || s_write !== 1'b0 || m1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_mid abandon got grant=%b w=%b w1=%b exp 00/0/1", grant, s_write, m1_waitrequest); end
    step();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL reset_mid rearb got grant=%b exp 01", grant); end
    clear_inputs();
    step();
  endtask

  // Transaction-level model: who owns the slave, who finished last, how long it has stalled
  task automatic test_random();
    int owner, last, cnt, kind;
    bit err, r0, r1, sw, req, oth, c0, c1;
    logic [1:0] eg;
    do_reset();
    owner = -1; last = 1; cnt = 0; err = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      r0 = m0_read | m0_write; r1 = m1_read | m1_write; sw = s_waitrequest;
      c0 = 0; c1 = 0;
      if (owner < 0) begin
        if (r0 && r1) owner = 1 - last;
        else if (r0)  owner = 0;
        else if (r1)  owner = 1;
        cnt = 0;
      end else begin
        req = (owner == 0) ? r0 : r1;
        oth = (owner == 0) ? r1 : r0;
        if (!req) begin
          owner = -1; cnt = 0;
        end else if (!sw) begin
          if (owner == 0) c0 = 1; else c1 = 1;
          last = owner;
          owner = oth ? 1 - owner : -1;
          cnt = 0;
        end else begin
          if (cnt < LIMIT) cnt++;
          if (cnt == LIMIT) err = 1;
        end
      end
      #1;
      if (c0 || !r0) begin
        if ($urandom_range(0, 9) < 6) begin
          kind = $urandom_range(0, 9);
          m0_read = (kind < 5) || (kind == 9); m0_write = (kind >= 5);
          m0_address = $urandom; m0_writedata = $urandom; m0_byteenable = 4'($urandom);
        end else begin
          m0_read = 0; m0_write = 0;
        end
      end else if ($urandom_range(0, 49) == 0) begin
        m0_read = 0; m0_write = 0;
      end
      if (c1 || !r1) begin
        if ($urandom_range(0, 9) < 6) begin
          kind = $urandom_range(0, 9);
          m1_read = (kind < 5) || (kind == 9); m1_write = (kind >= 5);
          m1_address = $urandom; m1_writedata = $urandom; m1_byteenable = 4'($urandom);
        end else begin
          m1_read = 0; m1_write = 0;
        end
      end else if ($urandom_range(0, 49) == 0) begin
        m1_read = 0; m1_write = 0;
      end
      s_waitrequest = ($urandom_range(0, 99) < 35);
      s_readdata = $urandom;
      #1;
      eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      n_checks++; if (grant !== eg) begin n_fail++; $display("FAIL random cyc%0d grant got=%b exp=%b", cyc, grant, eg); end
      n_checks++; if (stall_error !== err) begin n_fail++; $display("FAIL random cyc%0d stall_error got=%b exp=%b", cyc, stall_error, err); end
      n_checks++;
      if (m0_waitrequest !== ((owner == 0) ? s_waitrequest : 1'b1) || m1_waitrequest !== ((owner == 1) ? s_waitrequest : 1'b1))
        begin n_fail++; $display("FAIL random cyc%0d waitreq got=%b%b owner=%0d slave=%b", cyc, m0_waitrequest, m1_waitrequest, owner, s_waitrequest); end
      n_checks++;
      if (m0_readdata !== ((owner == 0) ? s_readdata : 32'h0) || m1_readdata !== ((owner == 1) ? s_readdata : 32'h0))
        begin n_fail++; $display("FAIL random cyc%0d readdata got=%h/%h owner=%0d slave=%h", cyc, m0_readdata, m1_readdata, owner, s_readdata); end
      n_checks++;
      if (owner == 0) begin
        if (s_read !== m0_read || s_write !== m0_write || s_address !== m0_address || s_writedata !== m0_writedata || s_byteenable !== m0_byteenable)
          begin n_fail++; $display("FAIL random cyc%0d slave fwd from m0 got r=%b w=%b a=%h", cyc, s_read, s_write, s_address); end
      end else if (owner == 1) begin
        if (s_read !== m1_read || s_write !== m1_write || s_address !== m1_address || s_writedata !== m1_writedata || s_byteenable !== m1_byteenable)
          begin n_fail++; $display("FAIL random cyc%0d slave fwd from m1 got r=%b w=%b a=%h", cyc, s_read, s_write, s_address); end
      end else begin
        if (s_read !== 1'b0 || s_write !== 1'b0)
          begin n_fail++; $display("FAIL random cyc%0d idle slave cmd got r=%b w=%b exp 0/0", cyc, s_read, s_write); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_alternate();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
